// File: rtl/sc_backg_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sc_backg_lane_scheduler
// Purpose  : Sequences the bank of per-lane background shift registers:
//            broadcast clear/load strobes and one round-robin rotate command
//            per level-scaled scheduler tick.
// Revision : 1.0 - initial release
// ============================================================================
module sc_backg_lane_scheduler #(
  parameter int                   NUM_LANES      = 4,
  parameter int                   PRESCALE       = 5000000,
  parameter int                   PRESCALE_WIDTH = 24,
  parameter logic [NUM_LANES-1:0] DIR_MASK       = 4'b1010
) (
  input  logic                   SC_BackgSched_CLOCK_50,
  input  logic                   SC_BackgSched_RESET_InHigh,
  input  logic                   SC_BackgSched_start_InHigh,
  input  logic                   SC_BackgSched_pause_InHigh,
  input  logic                   SC_BackgSched_loadreq_InHigh,
  input  logic                   SC_BackgSched_gameover_InHigh,
  input  logic [1:0]             SC_BackgSched_level_In,
  output logic                   SC_BackgSched_clear_OutLow,
  output logic                   SC_BackgSched_load_OutLow,
  output logic [2*NUM_LANES-1:0] SC_BackgSched_shiftselection_OutBUS,
  output logic [2:0]             SC_BackgSched_laneptr_Out,
  output logic [2:0]             SC_BackgSched_state_Out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_CLEAR = 3'b001,
    S_RUN   = 3'b010,
    S_PAUSE = 3'b011,
    S_LOAD  = 3'b100
  } state_t;

  state_t                    state, state_d;
  logic [PRESCALE_WIDTH-1:0] prescaler, prescaler_d;
  logic [2:0]                laneptr, laneptr_d, laneptr_inc;
  logic                      clear_n, clear_n_d;
  logic                      load_n, load_n_d;
  logic [2*NUM_LANES-1:0]    shiftsel, shiftsel_d, shift_vec;
  logic [31:0]               shifted, term_full;
  logic                      tick;

  // Terminal count for the current level; >= compare lets a faster level fire at once.
  always_comb begin
    shifted   = 32'(PRESCALE) >> SC_BackgSched_level_In;
    term_full = (shifted == 32'd0) ? 32'd0 : shifted - 32'd1;
    tick      = (32'(prescaler) >= term_full);
  end

  // Rotate code for the lane under the pointer; every other lane gets 00.
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign shift_vec[2*g+1:2*g] = (laneptr == 3'(g)) ?
                                    (DIR_MASK[g] ? 2'b10 : 2'b01) : 2'b00;
    end
  endgenerate

  assign laneptr_inc = (laneptr == 3'(NUM_LANES-1)) ? 3'd0 : laneptr + 3'd1;

  // Next-state and next-output decode; priority gameover > loadreq > pause > tick.
  always_comb begin
    state_d     = state;
    prescaler_d = prescaler;
    laneptr_d   = laneptr;
    clear_n_d   = 1'b1;
    load_n_d    = 1'b1;
    shiftsel_d  = '0;
    case (state)
      S_IDLE: begin
        prescaler_d = '0;
        if (SC_BackgSched_start_InHigh) begin
          state_d   = S_CLEAR;
          clear_n_d = 1'b0;
          laneptr_d = 3'd0;
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (SC_BackgSched_gameover_InHigh) begin
          state_d     = S_IDLE;
          laneptr_d   = 3'd0;
          prescaler_d = '0;
        end else if (SC_BackgSched_loadreq_InHigh) begin
          state_d     = S_LOAD;
          load_n_d    = 1'b0;
          laneptr_d   = 3'd0;
          prescaler_d = '0;
        end else if (SC_BackgSched_pause_InHigh) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          prescaler_d = '0;
          shiftsel_d  = shift_vec;
          laneptr_d   = laneptr_inc;
        end else begin
          prescaler_d = prescaler + 1'b1;
        end
      end
      S_PAUSE: begin
        if (SC_BackgSched_gameover_InHigh) begin
          state_d     = S_IDLE;
          laneptr_d   = 3'd0;
          prescaler_d = '0;
        end else if (SC_BackgSched_loadreq_InHigh) begin
          state_d     = S_LOAD;
          load_n_d    = 1'b0;
          laneptr_d   = 3'd0;
          prescaler_d = '0;
        end else if (!SC_BackgSched_pause_InHigh) begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (SC_BackgSched_gameover_InHigh) begin
          state_d     = S_IDLE;
          laneptr_d   = 3'd0;
          prescaler_d = '0;
        end else begin
          state_d = SC_BackgSched_pause_InHigh ? S_PAUSE : S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset aborts any in-flight strobe.
  always_ff @(posedge SC_BackgSched_CLOCK_50 or posedge SC_BackgSched_RESET_InHigh) begin
    if (SC_BackgSched_RESET_InHigh) begin
      state     <= S_IDLE;
      prescaler <= '0;
      laneptr   <= 3'd0;
      clear_n   <= 1'b1;
      load_n    <= 1'b1;
      shiftsel  <= '0;
    end else begin
      state     <= state_d;
      prescaler <= prescaler_d;
      laneptr   <= laneptr_d;
      clear_n   <= clear_n_d;
      load_n    <= load_n_d;
      shiftsel  <= shiftsel_d;
    end
  end

  assign SC_BackgSched_clear_OutLow          = clear_n;
  assign SC_BackgSched_load_OutLow           = load_n;
  assign SC_BackgSched_shiftselection_OutBUS = shiftsel;
  assign SC_BackgSched_laneptr_Out           = laneptr;
  assign SC_BackgSched_state_Out             = state;

endmodule
`default_nettype wire

// File: doc/sc_backg_lane_scheduler.md
Name: sc_backg_lane_scheduler

Overview:
- Sequencing controller for the bank of per-lane background-type shift registers in the Frogger playfield.
- Drives each lane register's active-low clear, active-low load and 2-bit shift-selection inputs.
- Issues exactly one single-cycle rotate command per scheduler tick, round-robin across lanes.
- The shift period scales with game level; the block handles start, pause, pattern reload and game-over.

Parameters:
NUM_LANES, 4, number of lane registers controlled (2..8)
PRESCALE, 5000000, base tick period in clocks at level 0
PRESCALE_WIDTH, 24, width of the prescaler counter
DIR_MASK, 4'b1010, bit i=1: lane i rotates right (shiftsel 10); bit i=0: rotates left (01)

Ports:
SC_BackgSched_CLOCK_50  in  1  system clock
SC_BackgSched_RESET_InHigh  in  1  asynchronous active-high reset
SC_BackgSched_start_InHigh  in  1  single-cycle start pulse
SC_BackgSched_pause_InHigh  in  1  level; 1 = freeze scheduling
SC_BackgSched_loadreq_InHigh  in  1  single-cycle request to reload lane patterns
SC_BackgSched_gameover_InHigh  in  1  single-cycle game-over pulse
SC_BackgSched_level_In  in  2  speed level 0..3
SC_BackgSched_clear_OutLow  out  1  broadcast clear to all lane registers
SC_BackgSched_load_OutLow  out  1  broadcast load to all lane registers
SC_BackgSched_shiftselection_OutBUS  out  2*NUM_LANES  lane i occupies bits [2i+1:2i]
SC_BackgSched_laneptr_Out  out  3  lane that receives the next shift
SC_BackgSched_state_Out  out  3  current FSM state code

Behaviour:
- Interface: one clock, SC_BackgSched_CLOCK_50. Reset SC_BackgSched_RESET_InHigh is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - state = IDLE (000); clear_OutLow = 1, load_OutLow = 1.
  - shiftselection = all zeros; laneptr = 0; prescaler = 0.
- State codes: IDLE 000, CLEAR 001, RUN 010, PAUSE 011, LOAD 100.
- Event priority, evaluated each cycle: gameover > loadreq > pause > tick.
- IDLE:
  - All outputs inactive; prescaler held at 0.
  - start=1 -> CLEAR.
  - start is ignored in every other state.
- CLEAR:
  - Exactly one cycle with clear_OutLow = 0.
  - laneptr <- 0, prescaler <- 0.
  - Next state RUN.
- RUN:
  - Prescaler increments every cycle.
  - Terminal count = (PRESCALE >> level) - 1, with a minimum of 0.
  - Compare is prescaler >= terminal, so a level raised mid-count fires on the next cycle, not after a wrap.
  - On terminal:
    - prescaler <- 0.
    - For exactly one cycle, the lane at laneptr gets shiftsel = (DIR_MASK[laneptr] ? 10 : 01). All other lanes get 00.
    - laneptr <- laneptr + 1, wrapping NUM_LANES-1 -> 0.
  - Shift commands are one-hot across lanes: never more than one lane nonzero in any cycle.
- PAUSE:
  - Entered from RUN while pause=1.
  - Prescaler and laneptr frozen; shiftselection = 0.
  - pause=0 -> RUN, resuming the count where it stopped.
- LOAD:
  - Entered from RUN or PAUSE on loadreq.
  - Exactly one cycle with load_OutLow = 0.
  - laneptr <- 0, prescaler <- 0.
  - Next state RUN, or PAUSE if pause=1.
  - loadreq in IDLE or CLEAR is ignored.
- gameover in RUN, PAUSE or LOAD:
  - Next state IDLE.
  - Any pending shift that cycle is suppressed; shiftselection = 0.
  - Lane registers keep their contents.
- Simultaneous events:
  - tick with loadreq or gameover: tick dropped, laneptr not advanced.
  - pause with terminal count: no shift issued, prescaler frozen at its value.
- clear_OutLow and load_OutLow are never low in the same cycle.
- Reset asserted mid-operation forces the reset values immediately; any in-flight clear, load or shift pulse is aborted.

Test Plan:
- Start: PRESCALE=8, NUM_LANES=4, level 0, DIR_MASK=1010. Reset, then start pulse -> clear_OutLow low for exactly 1 cycle. Then shift pulses every 8 clocks to lanes 0,1,2,3,0 with codes 01,10,01,10,01; laneptr wraps 3->0.
- Level change: raise level 0->2 when prescaler=5 -> terminal becomes 1. Shift fires the next cycle, then every 2 clocks.
- Pause: assert pause for 20 cycles mid-count at prescaler=3 -> no shift activity and state=011. After release, the next shift occurs 5 clocks later to the same laneptr.
- Load collision: loadreq in the same cycle as a terminal count -> load_OutLow low for 1 cycle and no shift that cycle. laneptr=0; next shift 8 clocks later to lane 0.
- Game-over: gameover during PAUSE -> state IDLE next cycle with all outputs inactive. A later start pulse repeats the CLEAR sequence.
- Async reset: assert reset during the load_OutLow=0 cycle -> outputs return to reset values without waiting for a clock edge; there is never a cycle where both clear_OutLow and load_OutLow are low.
